// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage, ALU control, condition codes and the M pipeline register.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   e_stall, e_bubble    hazard control for the M register (stall wins over bubble)
//   E_*                  decoded instruction fields from the E register
//   m_stat, W_stat       downstream status, blocks CC updates when not AOK
//   alu_op/alu_a/alu_b   ALU request; alu_res/alu_ovf/alu_zero come back combinationally
//   e_valE, e_dstE       forwarding outputs (same cycle)
//   cc                   {ZF,SF,OF}
//   M_*                  M pipeline register
// Option: define EXECUTE_CMOV_EN to make RRMOVQ a conditional move (dstE squashed when Cnd==0).
module execute_stage #(
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [2:0] STAT_AOK = 3'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_stall,
  input  logic        e_bubble,
  input  logic [2:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic [1:0]  alu_op,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_res,
  input  logic        alu_ovf,
  input  logic        alu_zero,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic [2:0]  cc,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);
`ifdef EXECUTE_CMOV_EN
  localparam bit CMOV = 1'b1;
`else
  localparam bit CMOV = 1'b0;
`endif
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_t;
  localparam m_t BUB = '{stat: STAT_AOK, icode: 4'h1, cnd: 1'b0, valE: 64'd0, valA: 64'd0, dstE: RNONE, dstM: RNONE};
  logic opq, push, pop, mem, cond, cnd, cc_en, zf, sf, of;
  logic [2:0] cc_q, cc_d;
  m_t m_q, m_d;
  always_comb begin
    opq = E_icode == 4'h6;
    push = E_icode == 4'h8 || E_icode == 4'hA;
    pop = E_icode == 4'h9 || E_icode == 4'hB;
    mem = E_icode == 4'h4 || E_icode == 4'h5;
    // CALL/PUSHQ decrement the stack pointer, so SUB overrides the default ADD
    alu_op = opq ? E_ifun[1:0] : push ? 2'b01 : 2'b00;
    alu_a = (opq || mem || push || pop) ? E_valB : 64'd0;
    alu_b = (opq || E_icode == 4'h2) ? E_valA : (mem || E_icode == 4'h3) ? E_valC : (push || pop) ? 64'd8 : 64'd0;
    {zf, sf, of} = cc_q;
    cond = 1'b0;
    case (E_ifun)
      4'd0: cond = 1'b1;
      4'd1: cond = (sf ^ of) | zf;
      4'd2: cond = sf ^ of;
      4'd3: cond = zf;
      4'd4: cond = ~zf;
      4'd5: cond = ~(sf ^ of);
      4'd6: cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
    cnd = (E_icode == 4'h7 || (CMOV && E_icode == 4'h2)) ? cond : 1'b1;
    e_valE = alu_res;
    e_dstE = (CMOV && E_icode == 4'h2 && !cnd) ? RNONE : E_dstE;
    // flags only change for a healthy OPq that is actually advancing
    cc_en = opq && E_stat == STAT_AOK && m_stat == STAT_AOK && W_stat == STAT_AOK && !e_stall;
    cc_d = cc_en ? {alu_zero, alu_res[63], alu_ovf} : cc_q;
    m_d = e_stall ? m_q : e_bubble ? BUB : '{E_stat, E_icode, cnd, e_valE, E_valA, e_dstE, E_dstM};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q <= BUB;
      cc_q <= 3'b100;
    end else begin
      m_q <= m_d;
      cc_q <= cc_d;
    end
  end
  assign cc = cc_q;
  assign {M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM} = m_q;
endmodule
